// File: rtl/pwm_motor_pkg.sv
// Shared types and constants for the PWM motor generator.
package pwm_motor_pkg;

    localparam int CNT_W_DEF = 16;

    typedef logic [CNT_W_DEF-1:0] pwm_cnt_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_GAP
    } pwm_state_t;

endpackage

// File: rtl/pwm_period_counter.sv
// Period counter for the PWM generator: counts 0..period-1 while enabled
// and flags the last count of each period.
module pwm_period_counter
    import pwm_motor_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] cnt,
    output logic             tick
);

    logic last;

    // Callers never run with period==0, so the wrapped period-1 is never reached.
    assign last = (cnt == period - CNT_W'(1));
    assign tick = en && last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= last ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pwm_motor_gen.sv
// Motor PWM generator with boundary-aligned shadow updates and a dead period on reversal.
// Optional duty ramping is enabled by defining PWM_RAMP_EN.
module pwm_motor_gen
    import pwm_motor_pkg::*;
#(
    parameter int CNT_W     = CNT_W_DEF,
    parameter int RAMP_STEP = 64
) (
    input  logic             ACLK,
    input  logic             ARESET,
    input  logic             cfg_enable,
    input  logic             cfg_dir,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_duty,
    input  logic             cfg_wr,
    output logic             pwm_out,
    output logic             dir_out,
    output logic             period_tick,
    output logic [CNT_W-1:0] duty_active,
    output logic             busy
);

`ifdef PWM_RAMP_EN
    localparam bit               RAMP_ON = 1'b1;
    localparam logic [CNT_W-1:0] STEP    = CNT_W'(RAMP_STEP);
`else
    // A full-range step always lands on the target in a single boundary.
    localparam bit               RAMP_ON = 1'b0;
    localparam logic [CNT_W-1:0] STEP    = CNT_W'(RAMP_STEP) | {CNT_W{1'b1}};
`endif

    function automatic logic [CNT_W-1:0] ramp_toward(input logic [CNT_W-1:0] cur,
                                                     input logic [CNT_W-1:0] tgt);
        if (tgt > cur) begin
            return (tgt - cur > STEP) ? cur + STEP : tgt;
        end else if (cur > tgt) begin
            return (cur - tgt > STEP) ? cur - STEP : tgt;
        end
        return cur;
    endfunction

    pwm_state_t       state, state_nxt;
    logic [CNT_W-1:0] sh_period, sh_duty;
    logic             sh_dir;
    logic [CNT_W-1:0] act_period, period_nxt, duty_nxt;
    logic             dir_nxt, busy_nxt;
    logic [CNT_W-1:0] eff_period, eff_duty;
    logic             eff_dir;
    logic [CNT_W-1:0] cnt;
    logic             tick, running;

    // A write landing on the boundary cycle is applied there.
    assign eff_period = cfg_wr ? cfg_period : sh_period;
    assign eff_duty   = cfg_wr ? cfg_duty   : sh_duty;
    assign eff_dir    = cfg_wr ? cfg_dir    : sh_dir;

    assign running     = cfg_enable && (state != ST_IDLE);
    assign period_tick = tick;

    pwm_period_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk    (ACLK),
        .rst    (ARESET),
        .en     (running),
        .clr    (!running),
        .period (act_period),
        .cnt    (cnt),
        .tick   (tick)
    );

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        period_nxt = act_period;
        duty_nxt   = duty_active;
        dir_nxt    = dir_out;
        busy_nxt   = busy | cfg_wr;
        case (state)
            ST_IDLE: begin
                if (cfg_enable && eff_period != '0) begin
                    state_nxt  = ST_RUN;
                    period_nxt = eff_period;
                    duty_nxt   = RAMP_ON ? '0 : eff_duty;
                    dir_nxt    = eff_dir;
                    busy_nxt   = 1'b0;
                end
            end
            ST_RUN: begin
                if (tick) begin
                    busy_nxt = 1'b0;
                    if (eff_period == '0) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        period_nxt = eff_period;
                        if (eff_dir != dir_out && duty_active != '0) begin
                            // Reversal under load: dead period first, direction still pending.
                            state_nxt = ST_GAP;
                            busy_nxt  = 1'b1;
                            duty_nxt  = RAMP_ON ? '0 : duty_active;
                        end else begin
                            dir_nxt  = eff_dir;
                            duty_nxt = ramp_toward(duty_active, eff_duty);
                        end
                    end
                end
            end
            ST_GAP: begin
                if (tick) begin
                    busy_nxt = 1'b0;
                    if (eff_period == '0) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt  = ST_RUN;
                        period_nxt = eff_period;
                        dir_nxt    = eff_dir;
                        duty_nxt   = ramp_toward(duty_active, eff_duty);
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        // Disable is immediate; applied settings are frozen, pending writes stay pending.
        if (!cfg_enable) begin
            state_nxt  = ST_IDLE;
            period_nxt = act_period;
            duty_nxt   = duty_active;
            dir_nxt    = dir_out;
            busy_nxt   = busy | cfg_wr;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            sh_period   <= '0;
            sh_duty     <= '0;
            sh_dir      <= 1'b0;
            act_period  <= '0;
            duty_active <= '0;
            dir_out     <= 1'b0;
            busy        <= 1'b0;
            pwm_out     <= 1'b0;
        end else begin
            if (cfg_wr) begin
                sh_period <= cfg_period;
                sh_duty   <= cfg_duty;
                sh_dir    <= cfg_dir;
            end
            act_period  <= period_nxt;
            duty_active <= duty_nxt;
            dir_out     <= dir_nxt;
            busy        <= busy_nxt;
            pwm_out     <= running && (state == ST_RUN) && (cnt < duty_active);
        end
    end

endmodule

// File: tb/tb_pwm_motor_gen.sv
// Self-checking bench for pwm_motor_gen (define PWM_RAMP_EN to exercise the ramp build).
module tb_pwm_motor_gen;

    localparam int LIMIT = 1000;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        cfg_enable, cfg_dir, cfg_wr;
    logic [15:0] cfg_period, cfg_duty;
    logic        pwm_out, dir_out, period_tick, busy;
    logic [15:0] duty_active;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    always #5 ACLK = ~ACLK;

    pwm_motor_gen #(.CNT_W(16), .RAMP_STEP(64)) dut (
        .ACLK        (ACLK),
        .ARESET      (ARESET),
        .cfg_enable  (cfg_enable),
        .cfg_dir     (cfg_dir),
        .cfg_period  (cfg_period),
        .cfg_duty    (cfg_duty),
        .cfg_wr      (cfg_wr),
        .pwm_out     (pwm_out),
        .dir_out     (dir_out),
        .period_tick (period_tick),
        .duty_active (duty_active),
        .busy        (busy)
    );

    // One-cycle register write; returns just after the capturing edge.
    task automatic pulse_wr(input logic [15:0] p, input logic [15:0] d, input logic dr);
        cfg_period = p;
        cfg_duty   = d;
        cfg_dir    = dr;
        cfg_wr     = 1'b1;
        @(posedge ACLK);
        #1 cfg_wr = 1'b0;
    endtask

    task automatic wait_tick();
        bit seen = 1'b0;
        for (int i = 0; i < LIMIT && !seen; i++) begin
            @(negedge ACLK);
            if (period_tick) seen = 1'b1;
        end
        if (!seen) begin
            errors++;
            $display("FAIL wait_tick: no period_tick within %0d cycles", LIMIT);
        end
    endtask

    // Counts one period starting the cycle after a tick, ending on the next tick.
    task automatic measure_period(output int len, output int highs,
                                  output logic first_busy, output logic end_dir);
        bit done = 1'b0;
        len = 0;
        highs = 0;
        first_busy = 1'bx;
        for (int i = 0; i < LIMIT && !done; i++) begin
            @(negedge ACLK);
            if (len == 0) first_busy = busy;
            len++;
            if (pwm_out) highs++;
            if (period_tick) done = 1'b1;
        end
        end_dir = dir_out;
    endtask

    task automatic test_reset();
        ARESET = 1'b1;
        repeat (2) @(negedge ACLK);
        checks++; if (pwm_out !== 1'b0) begin errors++; $display("FAIL reset_pwm: got %0b want 0", pwm_out); end
        checks++; if (dir_out !== 1'b0) begin errors++; $display("FAIL reset_dir: got %0b want 0", dir_out); end
        checks++; if (period_tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %0b want 0", period_tick); end
        checks++; if (duty_active !== 16'd0) begin errors++; $display("FAIL reset_duty: got %0d want 0", duty_active); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
        ARESET = 1'b0;
        @(negedge ACLK);
    endtask

    task automatic test_basic();
        int len, highs, e;
        logic fb, ed;
        cfg_enable = 1'b1;
        pulse_wr(16'd100, 16'd25, 1'b0);
        wait_tick();
        repeat (3) exp_q.push_back(25);
        for (int k = 0; k < 3; k++) begin
            measure_period(len, highs, fb, ed);
            e = exp_q.pop_front();
            checks++; if (highs !== e) begin errors++; $display("FAIL basic_high[%0d]: got %0d want %0d", k, highs, e); end
            checks++; if (len !== 100) begin errors++; $display("FAIL basic_len[%0d]: got %0d want 100", k, len); end
        end
        checks++; if (duty_active !== 16'd25) begin errors++; $display("FAIL basic_duty: got %0d want 25", duty_active); end
    endtask

    task automatic test_duty_update();
        int len = 0, highs = 0, e;
        logic fb, ed;
        bit done = 1'b0;
        exp_q.push_back(25);
        exp_q.push_back(60);
        for (int i = 0; i < LIMIT && !done; i++) begin
            @(negedge ACLK);
            len++;
            if (pwm_out) highs++;
            if (period_tick) done = 1'b1;
            else if (len == 10) begin
                cfg_duty = 16'd60;
                cfg_wr   = 1'b1;
                @(negedge ACLK);
                cfg_wr = 1'b0;
                len++;
                if (pwm_out) highs++;
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL upd_busy_set: got %0b want 1", busy); end
                checks++; if (duty_active !== 16'd25) begin errors++; $display("FAIL upd_duty_hold: got %0d want 25", duty_active); end
            end
        end
        e = exp_q.pop_front();
        checks++; if (highs !== e) begin errors++; $display("FAIL upd_old_high: got %0d want %0d", highs, e); end
        checks++; if (len !== 100) begin errors++; $display("FAIL upd_len: got %0d want 100", len); end
        measure_period(len, highs, fb, ed);
        e = exp_q.pop_front();
        checks++; if (highs !== e) begin errors++; $display("FAIL upd_new_high: got %0d want %0d", highs, e); end
        checks++; if (fb !== 1'b0) begin errors++; $display("FAIL upd_busy_clr: got %0b want 0", fb); end
    endtask

    task automatic test_reverse();
        int len, highs, e;
        logic fb, ed;
        // Written on the tick cycle, so it applies at this boundary.
        pulse_wr(16'd100, 16'd50, 1'b0);
        exp_q.push_back(50);
        measure_period(len, highs, fb, ed);
        e = exp_q.pop_front();
        checks++; if (highs !== e) begin errors++; $display("FAIL rev_pre_high: got %0d want %0d", highs, e); end
        pulse_wr(16'd100, 16'd50, 1'b1);
        exp_q.push_back(0);
        exp_q.push_back(50);
        measure_period(len, highs, fb, ed);
        e = exp_q.pop_front();
        checks++; if (highs !== e) begin errors++; $display("FAIL rev_gap_high: got %0d want %0d", highs, e); end
        checks++; if (len !== 100) begin errors++; $display("FAIL rev_gap_len: got %0d want 100", len); end
        checks++; if (ed !== 1'b0) begin errors++; $display("FAIL rev_gap_dir: got %0b want 0", ed); end
        checks++; if (fb !== 1'b1) begin errors++; $display("FAIL rev_gap_busy: got %0b want 1", fb); end
        measure_period(len, highs, fb, ed);
        e = exp_q.pop_front();
        checks++; if (highs !== e) begin errors++; $display("FAIL rev_post_high: got %0d want %0d", highs, e); end
        checks++; if (ed !== 1'b1) begin errors++; $display("FAIL rev_post_dir: got %0b want 1", ed); end
        checks++; if (fb !== 1'b0) begin errors++; $display("FAIL rev_post_busy: got %0b want 0", fb); end
    endtask

    task automatic test_extremes();
        int len, highs, ticks, e;
        logic fb, ed;
        pulse_wr(16'd100, 16'd120, 1'b1);
        exp_q.push_back(100);
        measure_period(len, highs, fb, ed);
        measure_period(len, highs, fb, ed);
        e = exp_q.pop_front();
        checks++; if (highs !== e) begin errors++; $display("FAIL ext_full_high: got %0d want %0d", highs, e); end
        pulse_wr(16'd100, 16'd0, 1'b1);
        exp_q.push_back(0);
        measure_period(len, highs, fb, ed);
        measure_period(len, highs, fb, ed);
        e = exp_q.pop_front();
        checks++; if (highs !== e) begin errors++; $display("FAIL ext_zero_high: got %0d want %0d", highs, e); end
        pulse_wr(16'd0, 16'd0, 1'b1);
        ticks = 0;
        highs = 0;
        repeat (300) begin
            @(negedge ACLK);
            if (period_tick) ticks++;
            if (pwm_out) highs++;
        end
        checks++; if (ticks !== 0) begin errors++; $display("FAIL ext_p0_ticks: got %0d want 0", ticks); end
        checks++; if (highs !== 0) begin errors++; $display("FAIL ext_p0_pwm: got %0d want 0", highs); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ext_p0_busy: got %0b want 0", busy); end
        pulse_wr(16'd1, 16'd1, 1'b1);
        repeat (2) @(negedge ACLK);
        ticks = 0;
        highs = 0;
        repeat (20) begin
            @(negedge ACLK);
            if (period_tick) ticks++;
            if (pwm_out) highs++;
        end
        checks++; if (ticks !== 20) begin errors++; $display("FAIL ext_p1_ticks: got %0d want 20", ticks); end
        checks++; if (highs !== 20) begin errors++; $display("FAIL ext_p1_pwm: got %0d want 20", highs); end
    endtask

    task automatic test_disable_reset();
        int n = 0;
        bit seen = 1'b0;
        pulse_wr(16'd100, 16'd60, 1'b1);
        wait_tick();
        repeat (40) @(negedge ACLK);
        checks++; if (pwm_out !== 1'b1) begin errors++; $display("FAIL dis_pre_pwm: got %0b want 1", pwm_out); end
        cfg_enable = 1'b0;
        @(negedge ACLK);
        checks++; if (pwm_out !== 1'b0) begin errors++; $display("FAIL dis_pwm: got %0b want 0", pwm_out); end
        checks++; if (duty_active !== 16'd60) begin errors++; $display("FAIL dis_duty_kept: got %0d want 60", duty_active); end
        repeat (4) @(negedge ACLK);
        cfg_enable = 1'b1;
        for (int i = 0; i < LIMIT && !seen; i++) begin
            @(negedge ACLK);
            n++;
            if (period_tick) seen = 1'b1;
        end
        checks++; if (n !== 100) begin errors++; $display("FAIL dis_restart_cnt: got %0d want 100", n); end
        repeat (20) @(negedge ACLK);
        checks++; if (pwm_out !== 1'b1 || dir_out !== 1'b1) begin
            errors++; $display("FAIL rst_pre: got pwm=%0b dir=%0b want 1/1", pwm_out, dir_out);
        end
        ARESET = 1'b1;
        #1;
        checks++; if (pwm_out !== 1'b0) begin errors++; $display("FAIL rst_pwm: got %0b want 0", pwm_out); end
        checks++; if (dir_out !== 1'b0) begin errors++; $display("FAIL rst_dir: got %0b want 0", dir_out); end
        checks++; if (duty_active !== 16'd0) begin errors++; $display("FAIL rst_duty: got %0d want 0", duty_active); end
        checks++; if (period_tick !== 1'b0) begin errors++; $display("FAIL rst_tick: got %0b want 0", period_tick); end
        repeat (2) @(negedge ACLK);
        ARESET = 1'b0;
        @(negedge ACLK);
    endtask

    task automatic test_ramp();
        int e;
        cfg_enable = 1'b1;
        pulse_wr(16'd300, 16'd200, 1'b0);
        @(negedge ACLK);
        checks++; if (duty_active !== 16'd0) begin errors++; $display("FAIL ramp_start: got %0d want 0", duty_active); end
        exp_q.push_back(64);
        exp_q.push_back(128);
        exp_q.push_back(192);
        exp_q.push_back(200);
        exp_q.push_back(200);
        for (int k = 0; k < 5; k++) begin
            wait_tick();
            @(negedge ACLK);
            e = exp_q.pop_front();
            checks++; if (duty_active !== 16'(e)) begin errors++; $display("FAIL ramp_step[%0d]: got %0d want %0d", k, duty_active, e); end
        end
    endtask

    initial begin
        ARESET     = 1'b1;
        cfg_enable = 1'b0;
        cfg_dir    = 1'b0;
        cfg_wr     = 1'b0;
        cfg_period = 16'd0;
        cfg_duty   = 16'd0;
        test_reset();
`ifdef PWM_RAMP_EN
        test_ramp();
`else
        test_basic();
        test_duty_update();
        test_reverse();
        test_extremes();
        test_disable_reset();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
